// File: rtl/mod_mem_port.sv
// Memory-access stage: issues one data-memory request per LW/SW and returns the write-back value.
// Latency: accept cycle + BUSY until mem_ack (or TIMEOUT cycles) + one DONE cycle; min 3 cycles.
// Backpressure: stall is high from the accept cycle through BUSY and drops in DONE to retire the op.
module mod_mem_port #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenable,
    input  logic        memwrite,
    input  logic [15:0] aluout,
    input  logic [15:0] SrcData2,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic [15:0] wbdata,
    output logic        mem_err,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last BUSY cycle index before the access is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic [15:0] addr_q;
    logic [15:0] data_q;
    logic        we_q;
    logic [15:0] ldata_q;
    logic        err_q;
    logic [15:0] stall_count_q;
    logic        busy;
    logic        timeout_hit;

    assign busy        = (state == BUSY);
    assign timeout_hit = (cnt == CNT_LAST);

    // Next-state and stall decode; stall in IDLE follows memenable so the accept cycle freezes too.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = memenable;
                if (memenable) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request latches, timeout counter, load-data capture and the timeout error pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q  <= 16'h0000;
            data_q  <= 16'h0000;
            we_q    <= 1'b0;
            cnt     <= 8'd0;
            ldata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            err_q <= busy && !mem_ack && timeout_hit;
            case (state)
                IDLE: begin
                    if (memenable) begin
                        addr_q <= aluout & 16'hFFFE;
                        data_q <= SrcData2;
                        we_q   <= memwrite;
                        cnt    <= 8'd0;
                    end
                end
                BUSY: begin
                    // Ack takes priority over a coincident timeout.
                    if (mem_ack) begin
                        ldata_q <= mem_rdata;
                    end else if (timeout_hit) begin
                        ldata_q <= 16'h0000;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Saturating count of stalled cycles, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_count_q <= 16'h0000;
        end else if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_q <= stall_count_q + 16'd1;
        end
    end

    // Memory-side outputs come from state and latches only; they read 0 outside BUSY.
    assign mem_req     = busy;
    assign mem_we      = busy & we_q;
    assign mem_addr    = busy ? addr_q : 16'h0000;
    assign mem_wdata   = busy ? data_q : 16'h0000;
    assign mem_err     = err_q;
    assign stall_count = stall_count_q;

    // Loads retire the captured data in DONE; everything else forwards the ALU result.
    assign wbdata = ((state == DONE) && !we_q) ? ldata_q : aluout;

endmodule

// File: tb/tb_mod_mem_port.sv
module tb_mod_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        memenable;
    logic        memwrite;
    logic [15:0] aluout;
    logic [15:0] SrcData2;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic [15:0] wbdata;
    logic        mem_err;
    logic [15:0] stall_count;

    int total = 0;
    int bad   = 0;
    int row   = 0;

    mod_mem_port #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .memenable  (memenable),
        .memwrite   (memwrite),
        .aluout     (aluout),
        .SrcData2   (SrcData2),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .stall      (stall),
        .wbdata     (wbdata),
        .mem_err    (mem_err),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // One row = inputs held for one cycle plus the outputs expected during that cycle.
    typedef struct {
        logic        rst;
        logic        men;
        logic        mwr;
        logic [15:0] alu;
        logic [15:0] src;
        logic [15:0] rd;
        logic        ack;
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wd;
        logic        stl;
        logic [15:0] wb;
        logic        err;
        logic [15:0] sc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic men, input logic mwr,
                                input logic [15:0] alu, input logic [15:0] src,
                                input logic [15:0] rd, input logic ack,
                                input logic req, input logic we, input logic [15:0] addr,
                                input logic [15:0] wd, input logic stl, input logic [15:0] wb,
                                input logic err, input logic [15:0] sc);
        vec_t v;
        v.rst = r;   v.men = men; v.mwr = mwr; v.alu = alu; v.src = src;
        v.rd  = rd;  v.ack = ack; v.req = req; v.we  = we;  v.addr = addr;
        v.wd  = wd;  v.stl = stl; v.wb  = wb;  v.err = err; v.sc  = sc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    // Drive a row after the falling edge, then compare once combinational outputs settle.
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst       = v.rst;
        memenable = v.men;
        memwrite  = v.mwr;
        aluout    = v.alu;
        SrcData2  = v.src;
        mem_rdata = v.rd;
        mem_ack   = v.ack;
        #1;
        chk("mem_req",     {15'd0, mem_req},   {15'd0, v.req});
        chk("mem_we",      {15'd0, mem_we},    {15'd0, v.we});
        chk("mem_addr",    mem_addr,           v.addr);
        chk("mem_wdata",   mem_wdata,          v.wd);
        chk("stall",       {15'd0, stall},     {15'd0, v.stl});
        chk("mem_err",     {15'd0, mem_err},   {15'd0, v.err});
        chk("stall_count", stall_count,        v.sc);
        if (!v.req) begin
            chk("wbdata", wbdata, v.wb);
        end
        row++;
    endtask

    initial begin
        rst = 1'b0; memenable = 1'b0; memwrite = 1'b0; aluout = 16'h0;
        SrcData2 = 16'h0; mem_rdata = 16'h0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);

        // reset state
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,16'h0000,0, 0,0,16'h0000,16'h0000,0,16'h0000,0,16'd0));
        // LW 0x1235, ack in 4th BUSY cycle with BEEF
        tbl.push_back(mk(1,1,0,16'h1235,16'h0000,16'h0000,0, 0,0,16'h0000,16'h0000,1,16'h1235,0,16'd0));
        tbl.push_back(mk(1,1,0,16'h1235,16'h0000,16'h0000,0, 1,0,16'h1234,16'h0000,1,16'h1235,0,16'd1));
        tbl.push_back(mk(1,1,0,16'h1235,16'h0000,16'h0000,0, 1,0,16'h1234,16'h0000,1,16'h1235,0,16'd2));
        tbl.push_back(mk(1,1,0,16'h1235,16'h0000,16'h0000,0, 1,0,16'h1234,16'h0000,1,16'h1235,0,16'd3));
        tbl.push_back(mk(1,1,0,16'h1235,16'h0000,16'hBEEF,1, 1,0,16'h1234,16'h0000,1,16'h1235,0,16'd4));
        tbl.push_back(mk(1,1,0,16'h1235,16'h0000,16'h0000,0, 0,0,16'h0000,16'h0000,0,16'hBEEF,0,16'd5));
        // SW 0x0040 <= A5A5, ack in first BUSY cycle
        tbl.push_back(mk(1,1,1,16'h0040,16'hA5A5,16'h0000,0, 0,0,16'h0000,16'h0000,1,16'h0040,0,16'd5));
        tbl.push_back(mk(1,1,1,16'h0040,16'hA5A5,16'h1111,1, 1,1,16'h0040,16'hA5A5,1,16'h0040,0,16'd6));
        tbl.push_back(mk(1,1,1,16'h0040,16'hA5A5,16'h0000,0, 0,0,16'h0000,16'h0000,0,16'h0040,0,16'd7));
        // non-memory pass-through, then stray ack in IDLE
        tbl.push_back(mk(1,0,0,16'h7FFF,16'h0000,16'h0000,0, 0,0,16'h0000,16'h0000,0,16'h7FFF,0,16'd7));
        tbl.push_back(mk(1,0,0,16'h0002,16'h0000,16'hDEAD,1, 0,0,16'h0000,16'h0000,0,16'h0002,0,16'd7));
        tbl.push_back(mk(1,0,0,16'h0003,16'h0000,16'h0000,0, 0,0,16'h0000,16'h0000,0,16'h0003,0,16'd7));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // LW with no ack: 16 BUSY cycles, then DONE with mem_err and zero data
        apply(mk(1,1,0,16'h2001,16'h0000,16'h0000,0, 0,0,16'h0000,16'h0000,1,16'h2001,0,16'd24 - 16'd17));
        for (int k = 1; k <= 16; k++) begin
            apply(mk(1,1,0,16'h2001,16'h0000,16'h0000,0, 1,0,16'h2000,16'h0000,1,16'h2001,0,16'(7 + k)));
        end
        apply(mk(1,1,0,16'h2001,16'h0000,16'h0000,0, 0,0,16'h0000,16'h0000,0,16'h0000,1,16'd24));
        apply(mk(1,0,0,16'h0000,16'h0000,16'h0000,0, 0,0,16'h0000,16'h0000,0,16'h0000,0,16'd24));

        // ack coincident with the timeout cycle: data kept, no error
        apply(mk(1,1,0,16'h3000,16'h0000,16'h0000,0, 0,0,16'h0000,16'h0000,1,16'h3000,0,16'd24));
        for (int k = 1; k <= 15; k++) begin
            apply(mk(1,1,0,16'h3000,16'h0000,16'h0000,0, 1,0,16'h3000,16'h0000,1,16'h3000,0,16'(24 + k)));
        end
        apply(mk(1,1,0,16'h3000,16'h0000,16'h5A5A,1, 1,0,16'h3000,16'h0000,1,16'h3000,0,16'd40));
        apply(mk(1,1,0,16'h3000,16'h0000,16'h0000,0, 0,0,16'h0000,16'h0000,0,16'h5A5A,0,16'd41));
        apply(mk(1,0,0,16'h0000,16'h0000,16'h0000,0, 0,0,16'h0000,16'h0000,0,16'h0000,0,16'd41));

        // reset on the 2nd BUSY cycle, late ack ignored, then back-to-back loads
        apply(mk(1,1,0,16'h4000,16'h0000,16'h0000,0, 0,0,16'h0000,16'h0000,1,16'h4000,0,16'd41));
        apply(mk(1,1,0,16'h4000,16'h0000,16'h0000,0, 1,0,16'h4000,16'h0000,1,16'h4000,0,16'd42));
        apply(mk(0,1,0,16'h4000,16'h0000,16'h0000,0, 1,0,16'h4000,16'h0000,1,16'h4000,0,16'd43));
        apply(mk(1,0,0,16'h0000,16'h0000,16'h9999,1, 0,0,16'h0000,16'h0000,0,16'h0000,0,16'd0));
        apply(mk(1,0,0,16'h0000,16'h0000,16'h0000,0, 0,0,16'h0000,16'h0000,0,16'h0000,0,16'd0));
        apply(mk(1,1,0,16'h4002,16'h0000,16'h0000,0, 0,0,16'h0000,16'h0000,1,16'h4002,0,16'd0));
        apply(mk(1,1,0,16'h4002,16'h0000,16'h1357,1, 1,0,16'h4002,16'h0000,1,16'h4002,0,16'd1));
        apply(mk(1,1,0,16'h4002,16'h0000,16'h0000,0, 0,0,16'h0000,16'h0000,0,16'h1357,0,16'd2));
        apply(mk(1,1,0,16'h4004,16'h0000,16'h0000,0, 0,0,16'h0000,16'h0000,1,16'h4004,0,16'd2));
        apply(mk(1,1,0,16'h4004,16'h0000,16'h2468,1, 1,0,16'h4004,16'h0000,1,16'h4004,0,16'd3));
        apply(mk(1,1,0,16'h4004,16'h0000,16'h0000,0, 0,0,16'h0000,16'h0000,0,16'h2468,0,16'd4));
        apply(mk(1,0,0,16'h0055,16'h0000,16'h0000,0, 0,0,16'h0000,16'h0000,0,16'h0055,0,16'd4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_mem_port.md
Name: mod_mem_port

Overview:
- Memory-access stage that consumes the execution stage's effective address (aluout) and store data (SrcData2).
- Drives a multi-cycle data-memory request/acknowledge interface and freezes the pipeline via `stall` while an access is outstanding.
- Returns the write-back value: load data for LW, the ALU result otherwise.
- Sits between the execution stage and write-back; `stall` feeds the pipeline-wide freeze.

Parameters:
TIMEOUT, 16, cycles in BUSY without mem_ack before the access is abandoned (legal range 2..255)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-low reset
memenable  input  1  current instruction is LW/SW
memwrite  input  1  1 = SW, 0 = LW; valid only with memenable
aluout  input  16  effective address from execution stage; also non-memory result
SrcData2  input  16  store data
mem_req  output  1  request to data memory
mem_we  output  1  write strobe qualifier for mem_req
mem_addr  output  16  word-aligned memory address
mem_wdata  output  16  store data to memory
mem_rdata  input  16  load data from memory, valid with mem_ack
mem_ack  input  1  memory completion, single-cycle pulse
stall  output  1  freeze request to upstream stages
wbdata  output  16  value forwarded to write-back
mem_err  output  1  one-cycle pulse: access timed out
stall_count  output  16  saturating count of cycles with stall=1

Behaviour:
- Reset (rst=0 at a clock edge), regardless of state:
  - state=IDLE; timeout counter, address/data/we latches, load-data register and stall_count all 0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_err=0.
  - Reset mid-BUSY abandons the access with no ack wait.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - memenable=0: stall=0, wbdata=aluout (combinational pass-through).
  - memenable=1: stall=1 combinationally. On the edge, latch addr=aluout&16'hFFFE, data=SrcData2, we=memwrite; clear counter; go BUSY.
- BUSY:
  - mem_req=1, stall=1. mem_addr/mem_wdata/mem_we come from the latches and are held stable for the whole of BUSY.
  - mem_ack=1: capture mem_rdata into the load-data register (captured for stores too; unused); go DONE.
  - No ack and counter==TIMEOUT-1: load-data register <= 16'h0000; mem_err=1 for the following DONE cycle; go DONE.
  - Otherwise counter++.
  - mem_ack on the same cycle as the timeout: ack wins, no mem_err.
- DONE (exactly 1 cycle):
  - mem_req=0, stall=0. The pipeline advances this cycle, retiring the memory instruction.
  - wbdata = load-data register if we=0, else aluout.
  - memenable is ignored here because it is the retiring instruction. Unconditionally go IDLE.
  - A memory op arriving next cycle starts a fresh access, so minimum LW/SW occupancy is 3 cycles with 2 stalled.
- mem_ack while in IDLE or DONE is ignored (no state or data change).
- mem_req is derived only from state (registered), never combinationally from inputs.
- mem_addr, mem_wdata and mem_we read 0 in IDLE and DONE.
- stall_count increments on every edge where stall=1, saturates at 16'hFFFF, and clears only on reset.

Test Plan:
- LW with address aluout=16'h1235, mem_ack 3 cycles after mem_req rises, mem_rdata=16'hBEEF -> mem_addr=16'h1234 and mem_we=0 throughout BUSY. stall high from the accept cycle until DONE. wbdata=16'hBEEF in DONE; stall_count=5.
- SW with aluout=16'h0040, SrcData2=16'hA5A5, ack in the first BUSY cycle -> mem_we=1, mem_wdata=16'hA5A5 for 1 cycle. DONE wbdata=16'h0040; 2 stall cycles total.
- Non-memory instruction, aluout=16'h7FFF -> stall=0, wbdata=16'h7FFF the same cycle. mem_req never asserts.
- LW with no ack, TIMEOUT=16 -> exactly 16 BUSY cycles, then DONE with mem_err=1 for 1 cycle and wbdata=16'h0000. FSM returns to IDLE.
- Ack coincident with the timeout cycle -> data captured, mem_err stays 0. A stray mem_ack in IDLE -> no effect.
- rst=0 asserted on the 2nd BUSY cycle -> next cycle mem_req=0, stall=0, stall_count=0. A later ack is ignored. A back-to-back LW after release completes normally.
